// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel debouncer.
//   - FSM state encoding (ZERO/WAIT0/ONE/WAIT1)
//   - clog2 / counter-width helpers used to size the per-channel counters
package debounce_pkg;

  localparam logic [1:0] ENC_ZERO  = 2'b00;
  localparam logic [1:0] ENC_WAIT0 = 2'b01;
  localparam logic [1:0] ENC_ONE   = 2'b10;
  localparam logic [1:0] ENC_WAIT1 = 2'b11;

  typedef enum logic [1:0] {
    ZERO  = ENC_ZERO,
    WAIT0 = ENC_WAIT0,
    ONE   = ENC_ONE,
    WAIT1 = ENC_WAIT1
  } state_t;

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((longint'(1) << i) < longint'(v)) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

  // Width that holds both the debounce reload value and the long-press threshold.
  function automatic int cnt_width(input int db, input int hold);
    return clog2(((db > hold) ? db : hold) + 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-FF synchroniser, 4-state debounce FSM, debounce
// down-counter and long-press up-counter.
// Ports:
//   clk, reset (async, active-high), tick_en (counter qualifier)
//   sw        raw asynchronous input
//   db_level  debounced level (registered)
//   rise_tick / fall_tick / hold_tick  registered 1-cycle pulses
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int DB_CYCLES   = 4,
  parameter int HOLD_CYCLES = 0,
  parameter int CNT_W       = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_en,
  input  logic sw,
  output logic db_level,
  output logic rise_tick,
  output logic fall_tick,
  output logic hold_tick
);

  localparam logic [CNT_W-1:0] DB_LOAD  = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);
  localparam bit               HOLD_ON  = (HOLD_CYCLES > 0);

  logic             ff1, ff2;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, hcnt, hcnt_nxt;
  logic             fired, fired_nxt;
  logic             rise_nxt, fall_nxt, hold_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ff1       <= 1'b0;
      ff2       <= 1'b0;
      state     <= ZERO;
      cnt       <= '0;
      hcnt      <= '0;
      fired     <= 1'b0;
      db_level  <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
      hold_tick <= 1'b0;
    end else begin
      ff1       <= sw;
      ff2       <= ff1;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hcnt      <= hcnt_nxt;
      fired     <= fired_nxt;
      db_level  <= (state_nxt == ONE) || (state_nxt == WAIT0);
      rise_tick <= rise_nxt;
      fall_tick <= fall_nxt;
      hold_tick <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hcnt_nxt  = hcnt;
    fired_nxt = fired;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    hold_nxt  = 1'b0;
    unique case (state)
      ZERO: begin
        // Entry into WAIT1 is not qualified by tick_en; only the countdown is.
        if (ff2) begin
          state_nxt = WAIT1;
          cnt_nxt   = DB_LOAD;
        end
      end
      WAIT1: begin
        if (!ff2) state_nxt = ZERO;
        else if (tick_en) begin
          if (cnt == '0) begin
            state_nxt = ONE;
            rise_nxt  = 1'b1;
            hcnt_nxt  = '0;
            fired_nxt = 1'b0;
          end else cnt_nxt = cnt - 1'b1;
        end
      end
      ONE: begin
        if (!ff2) begin
          state_nxt = WAIT0;
          cnt_nxt   = DB_LOAD;
        end else if (tick_en && HOLD_ON && !fired) begin
          hcnt_nxt = hcnt + 1'b1;
          if (hcnt_nxt == HOLD_MAX) begin
            hold_nxt  = 1'b1;
            fired_nxt = 1'b1;
          end
        end
      end
      WAIT0: begin
        // A bounce back to 1 resumes ONE with the long-press progress intact.
        if (ff2) state_nxt = ONE;
        else if (tick_en) begin
          if (cnt == '0) begin
            state_nxt = ZERO;
            fall_nxt  = 1'b1;
            fired_nxt = 1'b0;
          end else cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = ZERO;
    endcase
  end

endmodule

// File: rtl/debounce_multi.sv
// N-channel switch/button debouncer. Each channel is an independent
// debounce_chan; this level only fans out tick_en/sw and gathers outputs.
// Ports:
//   clk, reset (async, active-high), tick_en (counter qualifier)
//   sw[N_CH]         raw inputs
//   db_level[N_CH]   debounced levels
//   rise_tick/fall_tick/hold_tick[N_CH]  1-cycle pulses
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int DB_CYCLES   = 2000000,
  parameter int HOLD_CYCLES = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick_en,
  input  logic [N_CH-1:0] sw,
  output logic [N_CH-1:0] db_level,
  output logic [N_CH-1:0] rise_tick,
  output logic [N_CH-1:0] fall_tick,
  output logic [N_CH-1:0] hold_tick
);

  localparam int CNT_W = cnt_width(DB_CYCLES, HOLD_CYCLES);

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    debounce_chan #(
      .DB_CYCLES  (DB_CYCLES),
      .HOLD_CYCLES(HOLD_CYCLES),
      .CNT_W      (CNT_W)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .tick_en  (tick_en),
      .sw       (sw[i]),
      .db_level (db_level[i]),
      .rise_tick(rise_tick[i]),
      .fall_tick(fall_tick[i]),
      .hold_tick(hold_tick[i])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi (N_CH=4, DB_CYCLES=4, HOLD_CYCLES=10).
// A reference model steps on each rising edge and queues the expected
// outputs; a monitor on the falling edge pops and compares.
module tb_debounce_multi;
  localparam int N    = 4;
  localparam int DB   = 4;
  localparam int HOLD = 10;

  logic         clk = 1'b0;
  logic         reset, tick_en;
  logic [N-1:0] sw, db_level, rise_tick, fall_tick, hold_tick;

  always #5 clk = ~clk;

  debounce_multi #(.N_CH(N), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD)) dut (
    .clk      (clk),
    .reset    (reset),
    .tick_en  (tick_en),
    .sw       (sw),
    .db_level (db_level),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick),
    .hold_tick(hold_tick)
  );

  typedef struct packed {
    logic [N-1:0] lvl, rise, fall, hold;
  } obs_t;

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: a change of the synchronised input is accepted once it
  // has been seen on the first edge plus DB further qualified edges without
  // reverting; the long press counts qualified edges while settled high.
  logic [N-1:0] m_ff1, m_ff2, m_lvl, m_pend, m_fired;
  int           m_q[N], m_h[N];

  always @(posedge clk) begin
    obs_t         e;
    logic [N-1:0] s;
    e = '0;
    if (reset) begin
      m_ff1 = '0; m_ff2 = '0; m_lvl = '0; m_pend = '0; m_fired = '0;
      for (int i = 0; i < N; i++) begin m_q[i] = 0; m_h[i] = 0; end
    end else begin
      s     = m_ff2;
      m_ff2 = m_ff1;
      m_ff1 = sw;
      for (int i = 0; i < N; i++) begin
        if (s[i] == m_lvl[i]) begin
          if (m_lvl[i] && !m_pend[i] && tick_en && !m_fired[i]) begin
            m_h[i]++;
            if (m_h[i] == HOLD) begin e.hold[i] = 1'b1; m_fired[i] = 1'b1; end
          end
          m_pend[i] = 1'b0;
        end else if (!m_pend[i]) begin
          m_pend[i] = 1'b1;
          m_q[i]    = 0;
        end else if (tick_en) begin
          m_q[i]++;
          if (m_q[i] == DB) begin
            m_pend[i]  = 1'b0;
            m_lvl[i]   = s[i];
            m_fired[i] = 1'b0;
            if (s[i]) begin e.rise[i] = 1'b1; m_h[i] = 0; end
            else e.fall[i] = 1'b1;
          end
        end
      end
    end
    e.lvl = m_lvl;
    exp_q.push_back(e);
  end

  // Monitor
  always @(negedge clk) begin
    obs_t a, e;
    a = {db_level, rise_tick, fall_tick, hold_tick};
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL sb_empty t=%0t got=%h required an expected entry", $time, a);
    end else begin
      e = exp_q.pop_front();
      if (reset) e = '0;  // outputs must clear as soon as reset is seen
      if (a !== e) begin
        fails++;
        $display("FAIL outputs t=%0t got lvl=%h rise=%h fall=%h hold=%h required lvl=%h rise=%h fall=%h hold=%h",
                 $time, a.lvl, a.rise, a.fall, a.hold, e.lvl, e.rise, e.fall, e.hold);
      end
    end
    tests++;
    if (((rise_tick & fall_tick) | (fall_tick & hold_tick)) != '0) begin
      fails++;
      $display("FAIL pulse_overlap t=%0t rise=%h fall=%h hold=%h required disjoint",
               $time, rise_tick, fall_tick, hold_tick);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset with all switches high, then release -> all channels rise
    reset = 1'b1; sw = '1; tick_en = 1'b1;
    step(3);
    reset = 1'b0;
    step(DB + 5);
    sw = '0;
    step(DB + 5);
    // 2: single press on channel 0
    sw[0] = 1'b1;
    step(DB + 5);
    // 3: short bounce on channel 1
    sw[1] = 1'b1; step(3);
    sw[1] = 1'b0; step(10);
    // 4: long press on channel 2, bounce during release, then release
    sw[2] = 1'b1; step(30);
    sw[2] = 1'b0; step(2);
    sw[2] = 1'b1; step(15);
    sw[2] = 1'b0; step(DB + 5);
    // 5: prescaled counting on channel 3
    sw[3] = 1'b1;
    for (int k = 0; k < 28; k++) begin
      tick_en = (k % 4 == 3);
      step(1);
    end
    tick_en = 1'b1;
    step(4);
    // 6: reset while channel 0 is mid-debounce
    sw[0] = 1'b0; step(DB + 5);
    sw[0] = 1'b1; step(4);
    reset = 1'b1; step(2);
    reset = 1'b0; step(DB + 6);
    // Random phase
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 15) == 0) sw[i] = ~sw[i];
      tick_en = ($urandom_range(0, 3) != 0);
      reset   = ($urandom_range(0, 299) == 0);
      step(1);
    end
    reset = 1'b0; tick_en = 1'b1;
    step(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
